// File: rtl/shared_resource_pkg.sv
// shared_resource_pkg: shared types, sizes and the operation applied by the resource pipe
package shared_resource_pkg;
  localparam int NUM_REQ = 2;
  localparam int DATA_W = 32;
  typedef logic tag_t;
  typedef struct packed {
    logic valid;
    tag_t tag;
    logic [DATA_W-1:0] data;
  } stage_t;
  function automatic logic [DATA_W-1:0] resource_op(input logic [DATA_W-1:0] x);
    return x + DATA_W'(1);
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant over the eligible set, remembering the last winner
module rr_arbiter2
  import shared_resource_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] e,
  output logic [NUM_REQ-1:0] grant
);
  logic last;
  assign grant = (e == 2'b11) ? (last ? 2'b01 : 2'b10) : e;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last <= 1'b1;
    else if (|grant) last <= grant[1];
endmodule

// File: rtl/shared_resource_responder.sv
// shared_resource_responder: arbitrates two pipelines onto a fixed-latency +1 pipe and routes results back
module shared_resource_responder
  import shared_resource_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] operand_0,
  input  logic [DATA_W-1:0] operand_1,
  output logic [1:0]        grant,
  input  logic [1:0]        flush,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);
  stage_t st [LAT];
  stage_t head;
  logic stall;
  logic [1:0] e;
  assign head = st[LAT-1];
  // a flushed head cannot hold the pipe, so the slot frees up in the same cycle
  assign stall = head.valid && !rsp_ready[head.tag] && !flush[head.tag];
  assign e = req & ~flush & {2{!stall}};
  assign rsp_valid = {2{head.valid}} & {head.tag, !head.tag};
  assign rsp_data = head.data;
  rr_arbiter2 u_arb (
    .clk(clk),
    .reset(reset),
    .e(e),
    .grant(grant)
  );
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LAT; k++) busy = busy | st[k].valid;
  end
  for (genvar s = 0; s < LAT; s++) begin : g_stage
    stage_t nxt;
    if (s == 0) begin : g_first
      assign nxt = '{valid: |grant, tag: grant[1], data: resource_op(grant[1] ? operand_1 : operand_0)};
    end else begin : g_rest
      assign nxt = st[s-1];
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) st[s] <= '0;
      else if (!stall) st[s] <= '{valid: nxt.valid && !flush[nxt.tag], tag: nxt.tag, data: nxt.data};
      else st[s].valid <= st[s].valid && !flush[st[s].tag];
  end
endmodule

// File: tb/tb_shared_resource_responder.sv
// tb_shared_resource_responder: scenario tasks plus a cycle-accurate result scoreboard
module tb_shared_resource_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req, flush, rsp_ready, grant, rsp_valid;
  logic [31:0] operand_0, operand_1, rsp_data;
  logic busy;
  typedef struct {
    logic tag;
    logic [31:0] data;
    int due;
    int g;
  } ent_t;
  ent_t q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic last_m = 1'b1;
  logic [1:0] m_ev;
  logic m_eb;
  shared_resource_responder #(.DATA_W(32), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .operand_0(operand_0), .operand_1(operand_1),
    .grant(grant), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // scoreboard: head result is due in a known cycle; an unready head pushes every due cycle back
  always begin
    @(negedge clk);
    #4;
    if (reset) begin
      m_ev = (q.size() > 0 && q[0].due == cyc) ? (q[0].tag ? 2'b10 : 2'b01) : 2'b00;
      total++;
      if (rsp_valid !== m_ev) begin
        bad++;
        $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, m_ev);
      end
      if (m_ev != 2'b00) begin
        total++;
        if (rsp_data !== q[0].data) begin
          bad++;
          $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, q[0].data);
        end
      end
      m_eb = 1'b0;
      foreach (q[k]) if (q[k].g < cyc) m_eb = 1'b1;
      total++;
      if (busy !== m_eb) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_eb);
      end
      if (m_ev != 2'b00 && !flush[q[0].tag]) begin
        if (rsp_ready[q[0].tag]) void'(q.pop_front());
        else foreach (q[k]) q[k].due++;
      end
      for (int k = q.size() - 1; k >= 0; k--) if (flush[q[k].tag]) q.delete(k);
    end
  end
  task automatic step(input logic [1:0] r, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] f, input logic [1:0] rd, output logic [1:0] eg);
    logic st;
    logic [1:0] e;
    ent_t n;
    @(negedge clk);
    req = r;
    operand_0 = a;
    operand_1 = b;
    flush = f;
    rsp_ready = rd;
    st = q.size() > 0 && q[0].due == cyc && !rd[q[0].tag] && !f[q[0].tag];
    e = r & ~f & {2{!st}};
    eg = (e == 2'b11) ? (last_m ? 2'b01 : 2'b10) : e;
    if (eg != 2'b00) begin
      last_m = eg[1];
      n.tag = eg[1];
      n.data = eg[1] ? b + 32'd1 : a + 32'd1;
      n.due = cyc + LAT;
      n.g = cyc;
      q.push_back(n);
    end
    #4;
  endtask
  task automatic drain();
    logic [1:0] eg;
    int n = 0;
    while (q.size() > 0 && n < 30) begin
      step(2'b00, 32'd0, 32'd0, 2'b00, 2'b11, eg);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
  endtask
  task automatic test_reset();
    req = 2'b00;
    flush = 2'b00;
    rsp_ready = 2'b11;
    operand_0 = 32'd0;
    operand_1 = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    total += 3;
    if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    last_m = 1'b1;
  endtask
  task automatic test_contention();
    logic [1:0] eg;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 32'd5, 32'd100, 2'b00, 2'b11, eg);
      total++;
      if (grant !== exp_g[i]) begin bad++; $display("FAIL contention_grant%0d got=%b exp=%b", i, grant, exp_g[i]); end
    end
    drain();
  endtask
  task automatic test_single();
    logic [1:0] eg;
    step(2'b01, 32'h10, 32'd0, 2'b00, 2'b11, eg);
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", grant); end
    step(2'b00, 32'd0, 32'd0, 2'b00, 2'b11, eg);
    step(2'b00, 32'd0, 32'd0, 2'b00, 2'b11, eg);
    total += 2;
    if (rsp_valid !== 2'b01) begin bad++; $display("FAIL single_valid got=%b exp=01", rsp_valid); end
    if (rsp_data !== 32'h11) begin bad++; $display("FAIL single_data got=%h exp=00000011", rsp_data); end
    drain();
  endtask
  task automatic test_backpressure();
    logic [1:0] eg;
    int got = 0;
    for (int i = 0; i < 10; i++) begin
      step(got < 3 ? 2'b01 : 2'b00, 32'h20 + i, 32'd0, 2'b00, (i >= 2 && i <= 4) ? 2'b10 : 2'b11, eg);
      total++;
      if (grant !== eg) begin bad++; $display("FAIL bp_grant%0d got=%b exp=%b", i, grant, eg); end
      if (eg != 2'b00) got++;
    end
    drain();
  endtask
  task automatic test_flush();
    logic [1:0] eg;
    step(2'b10, 32'd0, 32'd7, 2'b00, 2'b11, eg);
    total++;
    if (grant !== 2'b10) begin bad++; $display("FAIL flush_grant1 got=%b exp=10", grant); end
    step(2'b01, 32'd3, 32'd0, 2'b10, 2'b11, eg);
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL flush_grant0 got=%b exp=01", grant); end
    drain();
  endtask
  task automatic test_flush_head();
    logic [1:0] eg;
    step(2'b10, 32'd0, 32'd9, 2'b00, 2'b11, eg);
    step(2'b00, 32'd0, 32'd0, 2'b00, 2'b11, eg);
    step(2'b01, 32'h30, 32'd0, 2'b00, 2'b00, eg);
    total++;
    if (grant !== 2'b00) begin bad++; $display("FAIL stall_grant got=%b exp=00", grant); end
    step(2'b01, 32'h31, 32'd0, 2'b10, 2'b00, eg);
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL flush_head_grant got=%b exp=01", grant); end
    drain();
  endtask
  task automatic test_wrap_reset();
    logic [1:0] eg;
    step(2'b01, 32'hFFFF_FFFF, 32'd0, 2'b00, 2'b11, eg);
    step(2'b00, 32'd0, 32'd0, 2'b00, 2'b11, eg);
    step(2'b00, 32'd0, 32'd0, 2'b00, 2'b11, eg);
    total++;
    if (rsp_data !== 32'd0) begin bad++; $display("FAIL wrap_data got=%h exp=00000000", rsp_data); end
    drain();
    step(2'b01, 32'd1, 32'd0, 2'b00, 2'b11, eg);
    step(2'b01, 32'd2, 32'd0, 2'b00, 2'b11, eg);
    @(posedge clk);
    req = 2'b00;
    #2 reset = 1'b0;
    #1;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL midreset_valid got=%b exp=00", rsp_valid); end
    q.delete();
    last_m = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step(2'b11, 32'd5, 32'd6, 2'b00, 2'b11, eg);
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL post_reset_tie got=%b exp=01", grant); end
    drain();
  endtask
  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_flush();
    test_flush_head();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shared_resource_responder.md
# shared_resource_responder

Responder end of the pipeline-to-shared-resource request protocol. Two pipelines raise requests with an operand. This block grants one per cycle by round-robin, runs the operand through a fixed-latency shared operation pipe, and returns each result to the pipeline that issued it. Backpressure from either consumer globally stalls the pipe. A per-pipeline flush kills that pipeline's in-flight work.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- LAT, 2, operation latency in cycles (≥1); number of pipe stages

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  2  req[i]: pipeline i requests; held until granted or flushed
- operand_0  in  DATA_W  operand from pipeline 0, valid while req[0]
- operand_1  in  DATA_W  operand from pipeline 1, valid while req[1]
- grant  out  2  one-hot or zero; combinational; operand accepted at the clock edge ending a granted cycle
- flush  in  2  flush[i]: discard all of pipeline i's in-flight work this cycle
- rsp_valid  out  2  one-hot or zero; result for pipeline i available
- rsp_ready  in  2  consumer i accepts result when rsp_valid[i] && rsp_ready[i]
- rsp_data  out  DATA_W  result; rsp_data = operand + 1, mod 2^DATA_W
- busy  out  1  any pipe stage holds a valid entry

## Operation
- The pipe has stages s1..sLAT. Each stage holds valid, tag (requester id) and data. s1 loads the granted operand. Each later stage loads its predecessor. Results leave from sLAT.
- rsp_valid[i] = sLAT.valid && sLAT.tag==i. rsp_data = sLAT.data. rsp_data is don't-care when not valid.
- The +1 is applied on entry to s1. Later stages copy data unchanged.
- stall = sLAT.valid && !rsp_ready[sLAT.tag].
  - While stall is high, every stage holds and grant = 0.
  - Bubbles are not collapsed; this is a global stall.
- Round-robin arbitration uses register last. Eligible set: e[i] = req[i] && !flush[i] && !stall.
  - Only one bit of e set: grant that bit.
  - Both bits set: grant the index ≠ last.
  - last updates to the granted index on every grant. It holds otherwise, including during stall.
- Flush:
  - On flush[i], clear valid in every stage whose tag==i at the coming edge. This applies whether or not the pipe is stalled, and includes an entry advancing between stages.
  - The same cycle, grant[i]=0.
  - If the stalled sLAT entry is flushed, stall drops in that cycle. The pipe advances and arbitration proceeds in that same cycle.
  - flush[0] and flush[1] may both be high; both take effect.
- A new grant is not blocked by a pipeline's own outstanding results. Any number of entries per requester may be in flight.

## Timing
- Reset values: all stage valids 0; last = 1 (requester 0 wins the first tie); grant = 0; rsp_valid = 0; busy = 0.
- Reset mid-operation discards all in-flight entries immediately, since reset is asynchronous.
- Latency: grant in cycle t gives rsp_valid in cycle t+LAT, provided there is no stall or flush.
- Throughput: one grant per cycle. Sustained back-to-back traffic delivers one result per cycle when rsp_ready stays high.
- A stall of k cycles delays every in-flight result by exactly k cycles. No entry is lost or duplicated.
- grant, rsp_valid and busy carry no combinational path from operand_*.

## Structure
- Package shared_resource_pkg holds:
  - NUM_REQ = 2
  - DATA_W default
  - typedef tag_t (1 bit)
  - typedef stage_t {valid, tag, data}
  - function resource_op (returns x+1)
- Sub-module rr_arbiter2 holds the last register and the grant logic. Its inputs are e[1:0] and its outputs are grant[1:0].
- The top level instantiates rr_arbiter2 and the generate-built stage array.

## Test plan
- Single request: req=01, operand_0=32'h0000_0010 → grant=01 same cycle; rsp_valid=01 and rsp_data=32'h0000_0011 exactly LAT cycles later.
- Contention: after reset, req=11 held for 4 cycles with operand_0=5 and operand_1=100 → grants 01,10,01,10; results in order 6,101,6,101 with matching rsp_valid.
- Backpressure: stream of 3 from pipeline 0; rsp_ready[0]=0 for 3 cycles when the first result appears → rsp_valid/rsp_data held stable; grant=0 during the stall; all 3 results delivered in order, each 3 cycles late.
- Flush in flight: grant pipeline 1 (operand 7), then flush[1] in the next cycle → no rsp_valid[1] ever asserts; an interleaved pipeline-0 entry still emerges on schedule.
- Flush of stalled head: sLAT holds pipeline 1, rsp_ready[1]=0, flush[1]=1 with req=01 → grant=01 in that same cycle; the pipe advances.
- Wrap and reset: operand 32'hFFFF_FFFF → rsp_data=0. Reset asserted with 2 entries in flight → busy=0 and rsp_valid=0 immediately; after release, the first tie goes to pipeline 0.
